// File: rtl/sdr_ft_tx.sv
// FTDI synchronous-FIFO transmit engine: prefetches words from a selector
// into a 3-entry skid buffer and writes them out in bursts framed by bus turnaround.
module sdr_ft_tx #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int BURST_LEN     = 256
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [FT_DATA_WIDTH-1:0] src_data_i,
    input  logic                     src_empty_i,
    output logic                     src_re_o,
    input  logic                     ft_txe_n_i,
    output logic                     ft_wr_n_o,
    output logic [FT_DATA_WIDTH-1:0] ft_data_o,
    output logic [3:0]               ft_be_o,
    output logic                     ft_data_oe_o,
    output logic [15:0]              word_cnt_o
);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, ARM, STREAM, GAP} state_t;

    state_t                   state;
    logic [1:0]               occ;
    logic                     rd_pend;
    logic                     init;
    logic [BW-1:0]            burst_cnt;
    logic [FT_DATA_WIDTH-1:0] skid [3];

    logic       push;
    logic       pop;
    logic       burst_done;
    logic       src_drained;
    logic [1:0] wr_idx;

    // Reads are throttled by buffer headroom only, never by txe_n, so the
    // skid buffer absorbs the words already in flight when the FTDI stalls.
    assign src_re_o    = ~src_empty_i & (({1'b0, occ} + {2'b00, rd_pend}) < 3'd3)
                         & ~reset_i & ~init;
    assign push        = rd_pend;
    assign burst_done  = (burst_cnt == BW'(BURST_LEN));
    assign src_drained = (occ == 2'd0) & ~rd_pend & src_empty_i;
    assign pop         = (state == STREAM) & ~ft_txe_n_i & (occ != 2'd0) & ~burst_done;
    assign wr_idx      = pop ? occ - 2'd1 : occ;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            occ     <= 2'd0;
            rd_pend <= 1'b0;
            init    <= 1'b1;
        end else begin
            init    <= 1'b0;
            rd_pend <= src_re_o;
            occ     <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: the data entries have no reset; occ alone defines which entries
    // hold valid words, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            skid[0] <= skid[1];
            skid[1] <= skid[2];
        end
        if (push) begin
            skid[wr_idx] <= src_data_i;
        end
    end

    // NOTE: the strobe/byte-enable defaults at the top are overridden later in
    // the same block; with non-blocking assignments the last one wins.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            word_cnt_o   <= 16'h0000;
            ft_wr_n_o    <= 1'b1;
            ft_data_o    <= '0;
            ft_be_o      <= 4'h0;
            ft_data_oe_o <= 1'b0;
        end else begin
            ft_wr_n_o <= 1'b1;
            ft_be_o   <= 4'h0;
            if (pop) begin
                ft_wr_n_o  <= 1'b0;
                ft_be_o    <= 4'hF;
                ft_data_o  <= skid[0];
                word_cnt_o <= word_cnt_o + 16'd1;
                burst_cnt  <= burst_cnt + BW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (~ft_txe_n_i && (occ != 2'd0 || rd_pend)) begin
                        state        <= ARM;
                        ft_data_oe_o <= 1'b1;
                    end
                end
                ARM: state <= STREAM;
                STREAM: begin
                    // Exits are taken on edges that never issue a write, so the
                    // final word is on the bus before drive is released.
                    if (ft_txe_n_i || burst_done || src_drained) begin
                        state        <= GAP;
                        ft_data_oe_o <= 1'b0;
                        burst_cnt    <= '0;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdr_ft_tx.md
SDR_FT_TX -- requirements
Module: sdr_ft_tx

Interface
Parameters:
REQ-001 SHALL have parameter FT_DATA_WIDTH, default 32: width of the FTDI data bus and the source data.
REQ-002 SHALL have parameter BURST_LEN, default 256: maximum words per FTDI write burst.
Ports:
REQ-003 SHALL have port clk_i, input, 1: FTDI bus clock (100 MHz); sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port src_data_i, input, FT_DATA_WIDTH: word from the FIFO/CPU selector, valid exactly 1 cycle after src_re_o is sampled high.
REQ-006 SHALL have port src_empty_i, input, 1: selector has no word available.
REQ-007 SHALL have port src_re_o, output, 1: read strobe to the selector.
REQ-008 SHALL have port ft_txe_n_i, input, 1: FTDI TX FIFO has space when low.
REQ-009 SHALL have port ft_wr_n_o, output, 1: FTDI write strobe, active low.
REQ-010 SHALL have port ft_data_o, output, FT_DATA_WIDTH: FTDI data bus.
REQ-011 SHALL have port ft_be_o, output, 4: FTDI byte enables.
REQ-012 SHALL have port ft_data_oe_o, output, 1: bus drive enable for the bidirectional pads.
REQ-013 SHALL have port word_cnt_o, output, 16: count of words written to the FTDI.

Function
REQ-014 SHALL hold a 3-entry skid buffer (occupancy occ 0..3) plus a read-pending flag rd_pend.
- rd_pend is src_re_o registered.
REQ-015 SHALL drive src_re_o combinationally as ~src_empty_i & (occ + rd_pend < 3) & ~reset_i, with no combinational path from ft_txe_n_i.
REQ-016 SHALL push src_data_i into the buffer on every edge where rd_pend=1.
- Push and pop on the same edge SHALL leave occ unchanged.
- occ SHALL never exceed 3 or underflow.
REQ-017 SHALL implement FSM states IDLE, ARM, STREAM, GAP.
REQ-018 SHALL transition IDLE->ARM when ft_txe_n_i=0 and (occ>0 or rd_pend=1).
REQ-019 SHALL, in ARM, assert ft_data_oe_o for one turnaround cycle with ft_wr_n_o=1, then go to STREAM.
REQ-020 SHALL, in STREAM, perform a write when, at an edge, ft_txe_n_i=0 and occ>0.
- The head word is popped at that edge.
- In the next cycle ft_wr_n_o=0, ft_data_o=word, ft_be_o=4'hF.
- The write outputs are registered, giving 1-cycle latency from the decision.
REQ-021 SHALL, in cycles without a write, drive ft_wr_n_o=1 and ft_be_o=4'h0 and hold ft_data_o at its last value.
REQ-022 SHALL leave STREAM for GAP on the first of the following:
- BURST_LEN words written in the burst;
- ft_txe_n_i=1 sampled;
- occ=0 & rd_pend=0 & src_empty_i=1.
REQ-023 SHALL, in GAP, deassert ft_data_oe_o for one cycle, then return to IDLE; the burst word counter clears on leaving STREAM.
REQ-024 SHALL keep buffered words across bursts, so a txe_n stall loses no data and duplicates no data.
REQ-025 SHALL increment word_cnt_o by 1 per write cycle, wrapping 16'hFFFF->16'h0000.
REQ-026 SHALL prefetch from the source in every state, including IDLE, subject to REQ-015.
REQ-027 SHALL, when ft_txe_n_i rises in the same cycle a write is decided, still complete that single write and then enter GAP.

Reset
REQ-028 SHALL, while reset_i=1, force the following values:
- state=IDLE, occ=0, rd_pend=0, burst counter=0, word_cnt_o=0;
- ft_wr_n_o=1, ft_data_o=0, ft_be_o=0, ft_data_oe_o=0, src_re_o=0.
REQ-029 SHALL, when reset is asserted mid-burst, discard buffered and in-flight words and release the bus immediately, asynchronously.
REQ-030 SHALL take no read and no write in the first cycle after reset_i falls.

Verification
REQ-031 SHALL pass these directed scenarios:
- Streaming: source supplies 0x1..0x200, txe_n=0 always -> two bursts of 256 words, each preceded by ARM and followed by GAP; data in order, no gaps within a burst; word_cnt_o=512.
- Stall: txe_n rises after word 10 for 20 cycles -> burst ends after word 10 (REQ-027), occ=3, src_re_o=0; after txe_n falls, words 11.. resume with none lost or duplicated.
- Underrun: src_empty_i toggles every 4 cycles -> bursts end on drain; every word written exactly once; ft_be_o=F only with ft_wr_n_o=0.
- Reset mid-burst: reset_i pulses while occ=2 -> outputs take REQ-028 values within the same cycle; the next stream restarts at the source's next word; word_cnt_o=0.
- Counter wrap: preload 65535 writes (or force the count) -> the next write gives word_cnt_o=0.
- Throughput check: no cycle with src_re_o=1 and occ+rd_pend=3; sustained 1 word/cycle when txe_n=0 and the source is non-empty.
